// File: rtl/test_pattern_stream_gen_if.sv
// Pixel stream handshake between the test pattern generator and its sink.
// The master drives valid/data/sop/eop and the slave drives ready.
// A beat is taken on a rising clock edge where valid and ready are both high.
interface test_pattern_stream_gen_if #(
    parameter int BPC = 8
) ();
    logic               valid;
    logic               ready;
    logic [3*BPC-1:0]   data;
    logic               sop;
    logic               eop;

    modport master (output valid, output data, output sop, output eop, input ready);
    modport slave  (input valid, input data, input sop, input eop, output ready);
endinterface

// File: rtl/test_pattern_stream_gen.sv
// Video test pattern generator: streams one frame of W x H pixels with sop/eop.
// Patterns: colour bars, scrolling colour bars, grey ramp, solid colour, checkerboard.
// Every output comes from a flop. The next pixel is computed one cycle ahead and
// loaded when the current beat transfers, so the stream runs at one pixel per cycle.
module test_pattern_stream_gen #(
    parameter int BPC       = 8,
    parameter int CNT_W     = 14,
    parameter int CELL_LOG2 = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [2:0]              pattern_i,
    input  logic [CNT_W-1:0]        width_i,
    input  logic [CNT_W-1:0]        height_i,
    input  logic [7:0]              shift_frames_i,
    input  logic [3*BPC-1:0]        solid_color_i,
    output logic [15:0]             frame_cnt_o,
    test_pattern_stream_gen_if.master stream
);
    localparam int PIX_W = 3 * BPC;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [2:0]         pat_q, pat_d;
    logic [CNT_W-1:0]   w_q, w_d, h_q, h_d, bw_q, bw_d;
    logic [7:0]         shf_q, shf_d;
    logic [PIX_W-1:0]   solid_q, solid_d;
    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d, bcnt_q, bcnt_d;
    logic [2:0]         bar_q, bar_d, shift_q, shift_d;
    logic [7:0]         fss_q, fss_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [PIX_W-1:0]   data_q, data_d;

    logic               start_ok_s, xfer_s, load_s, adv_s;
    logic [CNT_W-1:0]   bw_in_s;
    logic [2:0]         sbar_s;
    logic [BPC-1:0]     ramp_s;

    // Replicate a one-bit-per-channel colour into full on/off components.
    function automatic logic [PIX_W-1:0] expand_rgb(input logic [2:0] rgb);
        expand_rgb = {{BPC{rgb[2]}}, {BPC{rgb[1]}}, {BPC{rgb[0]}}};
    endfunction

    // Colour bar table: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            3'd7:    bar_rgb = 3'b000;
            default: bar_rgb = 3'b000;
        endcase
    endfunction

    assign start_ok_s = enable_i && (width_i != '0) && (height_i != '0);
    assign xfer_s     = valid_q && stream.ready;
    // Bar width is W/8, but never less than one pixel for narrow frames.
    assign bw_in_s    = ((width_i >> 3) == '0) ? CNT_W'(1) : (width_i >> 3);

    // Frame sequencing, coordinate/bar sub-counters and next-pixel colour.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        w_d         = w_q;
        h_d         = h_q;
        bw_d        = bw_q;
        shf_d       = shf_q;
        solid_d     = solid_q;
        x_d         = x_q;
        y_d         = y_q;
        bcnt_d      = bcnt_q;
        bar_d       = bar_q;
        shift_d     = shift_q;
        fss_d       = fss_q;
        frame_cnt_d = frame_cnt_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        data_d      = data_q;
        load_s      = 1'b0;
        adv_s       = 1'b0;
        sbar_s      = 3'd0;
        ramp_s      = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (xfer_s && eop_q) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    // Scroll the bars once every shift_frames+1 completed frames.
                    if (fss_q == shf_q) begin
                        shift_d = shift_q + 3'd1;
                        fss_d   = 8'd0;
                    end else begin
                        fss_d   = fss_q + 8'd1;
                    end
                    if (start_ok_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        sop_d   = 1'b0;
                        eop_d   = 1'b0;
                        data_d  = '0;
                    end
                end else if (xfer_s) begin
                    adv_s = 1'b1;
                end else begin
                    adv_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_s) begin
            state_d = ST_ACTIVE;
            pat_d   = pattern_i;
            w_d     = width_i;
            h_d     = height_i;
            bw_d    = bw_in_s;
            shf_d   = shift_frames_i;
            solid_d = solid_color_i;
            x_d     = '0;
            y_d     = '0;
            bar_d   = 3'd0;
            bcnt_d  = '0;
        end else if (adv_s) begin
            if (x_q == w_q - CNT_W'(1)) begin
                x_d    = '0;
                y_d    = y_q + CNT_W'(1);
                bar_d  = 3'd0;
                bcnt_d = '0;
            end else begin
                x_d = x_q + CNT_W'(1);
                // Bar index saturates at 7; leftover pixels of W not divisible by 8 stay black.
                if ((bar_q != 3'd7) && (bcnt_q == bw_q - CNT_W'(1))) begin
                    bar_d  = bar_q + 3'd1;
                    bcnt_d = '0;
                end else begin
                    bcnt_d = bcnt_q + CNT_W'(1);
                end
            end
        end else begin
            x_d = x_q;
        end

        if (load_s || adv_s) begin
            valid_d = 1'b1;
            sop_d   = (x_d == '0) && (y_d == '0);
            eop_d   = (x_d == w_d - CNT_W'(1)) && (y_d == h_d - CNT_W'(1));
            sbar_s  = bar_d + shift_d;
            ramp_s  = BPC'(x_d);
            case (pat_d)
                3'd0:    data_d = expand_rgb(bar_rgb(bar_d));
                3'd1:    data_d = expand_rgb(bar_rgb(sbar_s));
                3'd2:    data_d = {ramp_s, ramp_s, ramp_s};
                3'd3:    data_d = solid_d;
                3'd4:    data_d = (x_d[CELL_LOG2] ^ y_d[CELL_LOG2]) ? '0 : '1;
                default: data_d = '0;
            endcase
        end else begin
            sbar_s = 3'd0;
        end
    end

    // State, configuration, counters and output flops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            pat_q       <= 3'd0;
            w_q         <= '0;
            h_q         <= '0;
            bw_q        <= '0;
            shf_q       <= 8'd0;
            solid_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            bcnt_q      <= '0;
            bar_q       <= 3'd0;
            shift_q     <= 3'd0;
            fss_q       <= 8'd0;
            frame_cnt_q <= 16'd0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            w_q         <= w_d;
            h_q         <= h_d;
            bw_q        <= bw_d;
            shf_q       <= shf_d;
            solid_q     <= solid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            bcnt_q      <= bcnt_d;
            bar_q       <= bar_d;
            shift_q     <= shift_d;
            fss_q       <= fss_d;
            frame_cnt_q <= frame_cnt_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            data_q      <= data_d;
        end
    end

    assign stream.valid = valid_q;
    assign stream.data  = data_q;
    assign stream.sop   = sop_q;
    assign stream.eop   = eop_q;
    assign frame_cnt_o  = frame_cnt_q;
endmodule

// File: tb/tb_test_pattern_stream_gen.sv
// Self-checking bench for test_pattern_stream_gen (BPC=8, CNT_W=14, CELL_LOG2=5).
// A frame-level reference model computes each pixel from its (x,y) coordinates.
`timescale 1ns/1ps
module tb_test_pattern_stream_gen;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [2:0]  pattern_i = 3'd0;
    logic [13:0] width_i = 14'd0;
    logic [13:0] height_i = 14'd0;
    logic [7:0]  shift_frames_i = 8'd0;
    logic [23:0] solid_color_i = 24'd0;
    logic [15:0] frame_cnt_o;

    test_pattern_stream_gen_if #(.BPC(8)) sif ();

    test_pattern_stream_gen #(.BPC(8), .CNT_W(14), .CELL_LOG2(5)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .pattern_i      (pattern_i),
        .width_i        (width_i),
        .height_i       (height_i),
        .shift_frames_i (shift_frames_i),
        .solid_color_i  (solid_color_i),
        .frame_cnt_o    (frame_cnt_o),
        .stream         (sif)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model state: bar shift, frames since last shift, completed frames.
    int m_shift = 0;
    int m_fss = 0;
    int m_frames = 0;
    int lat_pat = 0;
    int lat_shf = 0;
    logic [23:0] lat_solid = 24'd0;

    logic [23:0] bdata[$];
    bit          bsop[$];
    bit          beop[$];

    logic [23:0] tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] model_pix(int pat, int w, int x, int y, int shift, logic [23:0] solid);
        int bw;
        int b;
        logic [7:0] r;
        bw = w / 8;
        if (bw < 1) bw = 1;
        b = x / bw;
        if (b > 7) b = 7;
        r = 8'(x % 256);
        case (pat)
            0: return tab[b];
            1: return tab[(b + shift) % 8];
            2: return {r, r, r};
            3: return solid;
            4: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'h000000 : 24'hFFFFFF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic model_clear();
        m_shift = 0;
        m_fss = 0;
        m_frames = 0;
    endtask

    task automatic do_reset();
        enable_i = 1'b0;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        model_clear();
        @(posedge clk_i); #1;
    endtask

    task automatic start_cfg(input int pat, input int w, input int h, input int shf, input logic [23:0] solid);
        pattern_i = 3'(pat);
        width_i = 14'(w);
        height_i = 14'(h);
        shift_frames_i = 8'(shf);
        solid_color_i = solid;
        enable_i = 1'b1;
        lat_pat = pat;
        lat_shf = shf;
        lat_solid = solid;
    endtask

    // Consume one frame (called at posedge+1), checking every beat against the model.
    task automatic run_frame(input int w, input int h, input int pct, input int max_wait,
                             input bit drop_enable, input int stop_at);
        int beats = 0;
        int waited = 0;
        int ex = 0;
        int ey = 0;
        bit prev_stall = 1'b0;
        logic [23:0] pd = 24'd0;
        logic ps = 1'b0;
        logic pe = 1'b0;
        logic [23:0] exp_d;
        bit xfer;
        bdata.delete();
        bsop.delete();
        beop.delete();
        while (beats < w * h) begin
            if (sif.valid !== 1'b1) begin
                if (beats > 0 || prev_stall) begin
                    checks++; errors++;
                    $display("FAIL valid_drop: valid=%b at beat %0d, required 1", sif.valid, beats);
                    return;
                end
                waited++;
                if (waited > max_wait) begin
                    checks++; errors++;
                    $display("FAIL start_latency: valid=0 after %0d cycles, required 1 within %0d", waited, max_wait);
                    return;
                end
            end else begin
                if (prev_stall) begin
                    checks++;
                    if ({sif.data, sif.sop, sif.eop} !== {pd, ps, pe}) begin
                        errors++;
                        $display("FAIL stall_hold: data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                                 sif.data, sif.sop, sif.eop, pd, ps, pe);
                    end
                end
                exp_d = model_pix(lat_pat, w, ex, ey, m_shift, lat_solid);
                checks++;
                if (sif.data !== exp_d) begin
                    errors++;
                    $display("FAIL pixel(%0d,%0d) pat %0d: data=%h, required %h", ex, ey, lat_pat, sif.data, exp_d);
                end
                checks++;
                if (sif.sop !== (ex == 0 && ey == 0)) begin
                    errors++;
                    $display("FAIL sop(%0d,%0d): sop=%b, required %b", ex, ey, sif.sop, (ex == 0 && ey == 0));
                end
                checks++;
                if (sif.eop !== (ex == w - 1 && ey == h - 1)) begin
                    errors++;
                    $display("FAIL eop(%0d,%0d): eop=%b, required %b", ex, ey, sif.eop, (ex == w - 1 && ey == h - 1));
                end
            end
            sif.ready = ($urandom_range(99) < pct);
            xfer = (sif.valid === 1'b1) && sif.ready;
            prev_stall = (sif.valid === 1'b1) && !sif.ready;
            pd = sif.data;
            ps = sif.sop;
            pe = sif.eop;
            if (xfer) begin
                bdata.push_back(sif.data);
                bsop.push_back(sif.sop);
                beop.push_back(sif.eop);
                beats++;
                ex++;
                if (ex == w) begin
                    ex = 0;
                    ey++;
                end
                if (beats == 1 && drop_enable) begin
                    // Mid-frame enable drop and config churn must not disturb this frame.
                    enable_i = 1'b0;
                    pattern_i = 3'($urandom);
                    width_i = 14'($urandom_range(1, 50));
                    height_i = 14'($urandom_range(1, 50));
                    shift_frames_i = 8'($urandom);
                    solid_color_i = 24'($urandom);
                end
            end
            @(posedge clk_i); #1;
            if (stop_at > 0 && beats == stop_at) return;
        end
        m_frames++;
        if (m_fss == lat_shf) begin
            m_shift = (m_shift + 1) % 8;
            m_fss = 0;
        end else begin
            m_fss++;
        end
        checks++;
        if (frame_cnt_o !== 16'(m_frames)) begin
            errors++;
            $display("FAIL frame_cnt: frame_cnt_o=%0d, required %0d", frame_cnt_o, m_frames);
        end
        if (drop_enable) begin
            checks++;
            if (sif.valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_eop: valid=%b, required 0", sif.valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        enable_i = 1'b0;
        sif.ready = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: %b, required 0", sif.valid); end
        checks++; if (sif.sop !== 1'b0) begin errors++; $display("FAIL reset_sop: %b, required 0", sif.sop); end
        checks++; if (sif.eop !== 1'b0) begin errors++; $display("FAIL reset_eop: %b, required 0", sif.eop); end
        checks++; if (sif.data !== 24'd0) begin errors++; $display("FAIL reset_data: %h, required 000000", sif.data); end
        checks++; if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: %0d, required 0", frame_cnt_o); end
        rst_i = 1'b1;
        model_clear();
        @(posedge clk_i); #1;
    endtask

    task automatic test_bars();
        start_cfg(0, 16, 2, 0, 24'h123456);
        @(posedge clk_i); #1;
        run_frame(16, 2, 100, 0, 1'b1, 0);
        checks++;
        if (bdata.size() != 32) begin
            errors++;
            $display("FAIL bars_beats: %0d transfers, required 32", bdata.size());
        end else begin
            checks++; if (bdata[0] !== 24'hFFFFFF) begin errors++; $display("FAIL bars_x0: %h, required FFFFFF", bdata[0]); end
            checks++; if (bdata[1] !== 24'hFFFFFF) begin errors++; $display("FAIL bars_x1: %h, required FFFFFF", bdata[1]); end
            checks++; if (bdata[2] !== 24'hFFFF00) begin errors++; $display("FAIL bars_x2: %h, required FFFF00", bdata[2]); end
            checks++; if (bdata[3] !== 24'hFFFF00) begin errors++; $display("FAIL bars_x3: %h, required FFFF00", bdata[3]); end
            checks++; if (bdata[14] !== 24'h000000) begin errors++; $display("FAIL bars_x14: %h, required 000000", bdata[14]); end
            checks++; if (bdata[15] !== 24'h000000) begin errors++; $display("FAIL bars_x15: %h, required 000000", bdata[15]); end
            checks++; if (bsop[0] !== 1'b1) begin errors++; $display("FAIL bars_sop: %b, required 1", bsop[0]); end
            checks++; if (beop[31] !== 1'b1) begin errors++; $display("FAIL bars_eop32: %b, required 1", beop[31]); end
        end
        checks++; if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL bars_frame_cnt: %0d, required 1", frame_cnt_o); end
    endtask

    task automatic test_shift();
        logic [23:0] first [4];
        logic [23:0] want  [4];
        want[0] = 24'hFFFFFF; want[1] = 24'hFFFFFF; want[2] = 24'hFFFF00; want[3] = 24'hFFFF00;
        do_reset();
        start_cfg(1, 16, 2, 1, 24'd0);
        @(posedge clk_i); #1;
        for (int f = 0; f < 4; f++) begin
            run_frame(16, 2, 100, 0, (f == 3), 0);
            first[f] = (bdata.size() > 0) ? bdata[0] : 24'hxxxxxx;
        end
        for (int f = 0; f < 4; f++) begin
            checks++;
            if (first[f] !== want[f]) begin
                errors++;
                $display("FAIL shift_bar0_frame%0d: %h, required %h", f, first[f], want[f]);
            end
        end
    endtask

    task automatic test_random_ready();
        int pat, w, h, shf;
        for (int i = 0; i < 6; i++) begin
            pat = $urandom_range(0, 4);
            w = $urandom_range(1, 40);
            h = $urandom_range(1, 6);
            shf = $urandom_range(0, 2);
            start_cfg(pat, w, h, shf, 24'($urandom));
            @(posedge clk_i); #1;
            run_frame(w, h, 50, 0, 1'b1, 0);
        end
        start_cfg(1, 24, 3, 0, 24'd0);
        @(posedge clk_i); #1;
        run_frame(24, 3, 50, 0, 1'b0, 0);
        run_frame(24, 3, 50, 0, 1'b1, 0);
    endtask

    task automatic test_ramp_checker();
        start_cfg(2, 300, 1, 0, 24'd0);
        @(posedge clk_i); #1;
        run_frame(300, 1, 100, 0, 1'b1, 0);
        checks++;
        if (bdata.size() != 300) begin
            errors++; $display("FAIL ramp_beats: %0d, required 300", bdata.size());
        end else begin
            checks++; if (bdata[255] !== 24'hFFFFFF) begin errors++; $display("FAIL ramp_x255: %h, required FFFFFF", bdata[255]); end
            checks++; if (bdata[256] !== 24'h000000) begin errors++; $display("FAIL ramp_x256: %h, required 000000", bdata[256]); end
        end
        start_cfg(4, 64, 33, 0, 24'd0);
        @(posedge clk_i); #1;
        run_frame(64, 33, 100, 0, 1'b1, 0);
        checks++;
        if (bdata.size() != 64 * 33) begin
            errors++; $display("FAIL checker_beats: %0d, required %0d", bdata.size(), 64 * 33);
        end else begin
            checks++; if (bdata[32] !== 24'h000000) begin errors++; $display("FAIL checker_32_0: %h, required 000000", bdata[32]); end
            checks++; if (bdata[32 * 64 + 32] !== 24'hFFFFFF) begin errors++; $display("FAIL checker_32_32: %h, required FFFFFF", bdata[32 * 64 + 32]); end
        end
    endtask

    task automatic test_tiny();
        bit seen = 1'b0;
        start_cfg(0, 1, 1, 0, 24'd0);
        @(posedge clk_i); #1;
        run_frame(1, 1, 100, 0, 1'b1, 0);
        checks++;
        if (bsop.size() != 1 || bsop[0] !== 1'b1 || beop[0] !== 1'b1) begin
            errors++;
            $display("FAIL tiny_sop_eop: beats=%0d sop/eop not both 1, required 1 beat with sop=1 eop=1", bsop.size());
        end
        start_cfg(0, 0, 4, 0, 24'd0);
        repeat (20) begin
            @(posedge clk_i); #1;
            if (sif.valid !== 1'b0) seen = 1'b1;
        end
        enable_i = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL zero_width: valid=1 seen, required valid=0 throughout");
        end
    endtask

    task automatic test_reset_mid();
        start_cfg(3, 16, 8, 0, 24'hA5C33C);
        @(posedge clk_i); #1;
        run_frame(16, 8, 100, 0, 1'b0, 50);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if ({sif.valid, sif.sop, sif.eop, sif.data, frame_cnt_o} !== 43'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: valid=%b sop=%b eop=%b data=%h cnt=%0d, required all 0",
                     sif.valid, sif.sop, sif.eop, sif.data, frame_cnt_o);
        end
        model_clear();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        run_frame(16, 8, 100, 0, 1'b1, 0);
        checks++;
        if (bsop.size() == 0 || bsop[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_restart_sop: beats=%0d, required first beat with sop=1", bsop.size());
        end
    endtask

    initial begin
        sif.ready = 1'b0;
        test_reset();
        test_bars();
        test_shift();
        test_random_ready();
        test_ramp_checker();
        test_tiny();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
